// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the SRAM stream reader.
// Optional stall counter is enabled by SRAM_STREAM_STALL_CNT_EN.
package sram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int STALL_W    = 16;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_stream_fifo.sv
// Two-entry output buffer between the SRAM read port and the stream.
// Head is the oldest entry; push and pop may happen in the same cycle.
module sram_stream_fifo
    import sram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  rptr_q;
    logic                  wptr_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rptr_q <= 1'b0;
            wptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= push_data;
                wptr_q        <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/sram_stream_reader.sv
// Streams a run of SRAM words out on a valid/ready port, hiding read latency.
// Define SRAM_STREAM_STALL_CNT_EN to add the stall_cnt output.
module sram_stream_reader
    import sram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_adr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_radr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef SRAM_STREAM_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]    stall_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE      = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [ADDR_WIDTH:0]   issue_rem_q, issue_rem_d;
    logic [ADDR_WIDTH:0]   pop_rem_q, pop_rem_d;
    logic                  inflight_q;
    logic                  zdone_q, zdone_d;
    logic                  last_pop;
    logic [1:0]            fifo_cnt;
    logic [1:0]            used;
    logic                  pop;
    logic                  issue;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign used      = fifo_cnt + {1'b0, inflight_q};

    // A pop this cycle frees a slot in time for the read issued now.
    assign issue = (state_q == ST_READ) && ((used < 2'd2) || pop);

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        issue_rem_d = issue_rem_q;
        pop_rem_d   = pop_rem_q;
        zdone_d     = 1'b0;
        last_pop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = ST_READ;
                        adr_d       = start_adr;
                        issue_rem_d = len;
                        pop_rem_d   = len;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    adr_d       = (adr_q == LAST_ADR) ? '0 : adr_q + 1'b1;
                    issue_rem_d = issue_rem_q - ONE;
                    if (issue_rem_q == ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: ;
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            pop_rem_d = pop_rem_q - ONE;
            if (pop_rem_q == ONE) begin
                last_pop = 1'b1;
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            issue_rem_q <= '0;
            pop_rem_q   <= '0;
            inflight_q  <= 1'b0;
            zdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            issue_rem_q <= issue_rem_d;
            pop_rem_q   <= pop_rem_d;
            inflight_q  <= issue;
            zdone_q     <= zdone_d;
        end
    end

    sram_stream_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_data(sram_rdata),
        .pop      (pop),
        .count    (fifo_cnt),
        .head     (out_data)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = last_pop | zdone_q;
    assign sram_ren  = issue;
    assign sram_radr = adr_q;

`ifdef SRAM_STREAM_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
        end else if (out_valid && !out_ready) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomised self-checking bench for sram_stream_reader.
// Set SRAM_STREAM_STALL_CNT_EN to also exercise the stall counter.
module tb_sram_stream_reader;

    localparam int DW    = 128;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_adr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, sram_ren, out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] sram_radr;
    logic [DW-1:0] sram_rdata = '0;
    logic [DW-1:0] out_data;
`ifdef SRAM_STREAM_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    logic [DW-1:0] mem [DEPTH];

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] got_q [$];
    int  ren_n, done_n, done_cyc, idle_cyc, max_ahead, unstable, busy_hi_n;
    bit  timed_out, wrap_seen;

    sram_stream_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_adr (start_adr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sram_ren  (sram_ren),
        .sram_radr (sram_radr),
        .sram_rdata(sram_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef SRAM_STREAM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after ren.
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= mem[sram_radr];
    end

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] adr, input int i);
        return mem[(int'(adr) + i) % DEPTH];
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        logic [5:0] pat;
        pat = 6'b101001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[c % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one transfer and records what the DUT did; tests judge the record.
    task automatic run_xfer(input logic [AW-1:0] adr, input logic [AW:0] n,
                            input int mode, input bit poke);
        int c, pops;
        bit prev_stall, have_last;
        logic [DW-1:0] pd;
        logic [AW-1:0] last_radr;
        got_q.delete();
        ren_n = 0; done_n = 0; done_cyc = -1; idle_cyc = -1;
        max_ahead = 0; unstable = 0; busy_hi_n = 0;
        timed_out = 0; wrap_seen = 0;
        pops = 0; prev_stall = 0; have_last = 0; pd = '0; last_radr = '0;
        @(posedge clk); #1;
        start = 1'b1; start_adr = adr; len = n; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        forever begin
            out_ready = ready_for(mode, c);
            if (poke && c == 2) begin
                start = 1'b1; start_adr = adr + AW'(5); len = 3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) busy_hi_n++;
            if (sram_ren) begin
                ren_n++;
                if (have_last && last_radr == AW'(DEPTH - 1) && sram_radr == '0)
                    wrap_seen = 1;
                last_radr = sram_radr;
                have_last = 1;
            end
            if (prev_stall && (!out_valid || out_data !== pd)) unstable++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                pops++;
            end
            if (ren_n - pops > max_ahead) max_ahead = ren_n - pops;
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!busy && idle_cyc < 0 && done_n > 0) idle_cyc = c;
            if (idle_cyc >= 0 && c >= idle_cyc + 2) break;
            if (c >= 3000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, sram_ren, out_valid} !== 4'b0 || sram_radr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b ren=%b valid=%b radr=%0d data=%h, want all 0",
                     busy, done, sram_ren, out_valid, sram_radr, out_data);
        end
`ifdef SRAM_STREAM_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 4; k++) mem[97 + k] = DW'(137 + k);
        run_xfer(AW'(97), 4, 0, 0);
        vectors++;
        if (got_q.size() != 4 || timed_out) begin
            errors++;
            $display("FAIL basic_count: got %0d words (timeout=%0d) want 4", got_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            vectors++;
            if (got_q[i] !== DW'(137 + i)) begin
                errors++;
                $display("FAIL basic_word%0d: got %0d want %0d", i, got_q[i], 137 + i);
            end
        end
        vectors++;
        if (ren_n != 4 || done_n != 1) begin
            errors++;
            $display("FAIL basic_pulses: ren=%0d done=%0d want 4 and 1", ren_n, done_n);
        end
        vectors++;
        if (done_cyc != 6 || idle_cyc != 7) begin
            errors++;
            $display("FAIL basic_timing: done_cyc=%0d idle_cyc=%0d want 6 and 7", done_cyc, idle_cyc);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
        run_xfer(AW'(1022), 4, 0, 0);
        vectors++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d words want 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            vectors++;
            if (got_q[i] !== DW'((1022 + i) % DEPTH)) begin
                errors++;
                $display("FAIL wrap_word%0d: got %0d want %0d", i, got_q[i], (1022 + i) % DEPTH);
            end
        end
        vectors++;
        if (!wrap_seen) begin
            errors++;
            $display("FAIL wrap_radr: radr 1023->0 step seen=%0d want 1", wrap_seen);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, DEPTH - 1));
        run_xfer(a, 8, 1, 0);
        vectors++;
        if (got_q.size() != 8 || timed_out) begin
            errors++;
            $display("FAIL bp_count: got %0d words (timeout=%0d) want 8", got_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            vectors++;
            if (got_q[i] !== exp_word(a, i)) begin
                errors++;
                $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_word(a, i));
            end
        end
        vectors++;
        if (max_ahead > 2 || unstable != 0 || ren_n != 8 || done_n != 1) begin
            errors++;
            $display("FAIL bp_rules: ahead=%0d unstable=%0d ren=%0d done=%0d want <=2,0,8,1",
                     max_ahead, unstable, ren_n, done_n);
        end
    endtask

    task automatic test_zero_len();
        run_xfer(AW'(55), 0, 0, 0);
        vectors++;
        if (ren_n != 0 || busy_hi_n != 0 || done_n != 1 || done_cyc != 1) begin
            errors++;
            $display("FAIL zero_len: ren=%0d busy_cycles=%0d done=%0d done_cyc=%0d want 0,0,1,1",
                     ren_n, busy_hi_n, done_n, done_cyc);
        end
    endtask

    task automatic test_busy_start();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, DEPTH - 1));
        run_xfer(a, 5, 0, 1);
        vectors++;
        if (got_q.size() != 5 || ren_n != 5 || done_n != 1) begin
            errors++;
            $display("FAIL busy_start: words=%0d ren=%0d done=%0d want 5,5,1",
                     got_q.size(), ren_n, done_n);
        end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            vectors++;
            if (got_q[i] !== exp_word(a, i)) begin
                errors++;
                $display("FAIL busy_start_word%0d: got %h want %h", i, got_q[i], exp_word(a, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, DEPTH - 1));
        @(posedge clk); #1;
        start = 1'b1; start_adr = a; len = 6; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sram_ren, out_valid} !== 4'b0 || sram_radr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b ren=%b valid=%b radr=%0d data=%h, want all 0",
                     busy, done, sram_ren, out_valid, sram_radr, out_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        a = AW'($urandom_range(0, DEPTH - 1));
        run_xfer(a, 2, 0, 0);
        vectors++;
        if (got_q.size() != 2 || ren_n != 2 || done_n != 1) begin
            errors++;
            $display("FAIL reset_restart: words=%0d ren=%0d done=%0d want 2,2,1",
                     got_q.size(), ren_n, done_n);
        end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            vectors++;
            if (got_q[i] !== exp_word(a, i)) begin
                errors++;
                $display("FAIL reset_restart_word%0d: got %h want %h", i, got_q[i], exp_word(a, i));
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int n, bad;
        for (int k = 0; k < DEPTH; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int it = 0; it < 6; it++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            n = $urandom_range(1, 24);
            run_xfer(a, (AW+1)'(n), 2, 0);
            bad = 0;
            for (int i = 0; i < got_q.size() && i < n; i++)
                if (got_q[i] !== exp_word(a, i)) bad++;
            vectors++;
            if (bad != 0 || got_q.size() != n || ren_n != n || done_n != 1
                || max_ahead > 2 || unstable != 0 || timed_out) begin
                errors++;
                $display("FAIL random%0d: adr=%0d len=%0d words=%0d bad=%0d ren=%0d done=%0d ahead=%0d unstable=%0d",
                         it, a, n, got_q.size(), bad, ren_n, done_n, max_ahead, unstable);
            end
        end
    endtask

    task automatic test_full_depth();
        logic [AW-1:0] a;
        int bad;
        a = AW'($urandom_range(0, DEPTH - 1));
        run_xfer(a, (AW+1)'(DEPTH), 0, 0);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < DEPTH; i++)
            if (got_q[i] !== exp_word(a, i)) bad++;
        vectors++;
        if (bad != 0 || got_q.size() != DEPTH || ren_n != DEPTH || done_cyc != DEPTH + 2) begin
            errors++;
            $display("FAIL full_depth: words=%0d bad=%0d ren=%0d done_cyc=%0d want %0d,0,%0d,%0d",
                     got_q.size(), bad, ren_n, done_cyc, DEPTH, DEPTH, DEPTH + 2);
        end
    endtask

`ifdef SRAM_STREAM_STALL_CNT_EN
    task automatic test_stall_cnt();
        int s;
        bit ended;
        s = 0;
        ended = 0;
        @(posedge clk); #1;
        start = 1'b1; start_adr = AW'(10); len = 3; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid && !out_ready) s++;
            @(posedge clk); #1;
            if (s == 5) out_ready = 1'b1;
            if (!busy && s == 5) begin
                ended = 1;
                break;
            end
        end
        vectors++;
        if (!ended || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_count: got %0d (ended=%0d) want 5", stall_cnt, ended);
        end
        start = 1'b1; len = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_clear: got %0d want 0", stall_cnt);
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_busy_start();
        test_reset_mid();
        test_random();
        test_full_depth();
`ifdef SRAM_STREAM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
